hazard_controller: RTL

Pipeline sequencing controller for the 5-stage RISC-V core. Decides each cycle whether the front end advances, stalls or flushes. It detects load-use hazards against the instruction in ID and drives the `pipeline_stall` input of the ID stage to insert a bubble. It squashes wrong-path instructions on a taken branch, and freezes the whole pipeline while data memory is not ready, with a bounded timeout and a stall-cycle statistic.

---
 rtl/hazard_controller.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline sequencing controller for the 5-stage RISC-V core. Each cycle it
// decides whether the front end advances, stalls for a load-use hazard,
// flushes wrong-path instructions on a taken branch, or freezes the whole
// pipeline while data memory is busy. A memory freeze is bounded by
// MEM_TIMEOUT and raises a sticky timeout flag when the bound is hit.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   MemRead_EX, RD_EX : EX instruction is a load / its destination register
//   RS1_ID, RS2_ID    : ID instruction source registers
//   OPCODE_ID         : ID instruction opcode (selects which sources are used)
//   Branch_taken_EX   : branch in EX resolved taken
//   mem_req_MEM       : MEM instruction is accessing data memory
//   mem_ready         : data memory completes the access this cycle
//   PCWrite, IF_IDWrite, pipeline_stall, IF_ID_flush, ID_EX_flush,
//   pipe_freeze       : combinational pipeline controls
//   mem_timeout       : sticky, a memory access exceeded MEM_TIMEOUT
//   stall_cycles      : saturating count of stalled or frozen cycles
//
// state    | meaning
// RUN      | pipeline flowing; a frozen cycle here is the first of an access
// MEM_WAIT | frozen on a data-memory access, timer counting down

module hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [4:0]       RD_EX,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic [6:0]       OPCODE_ID,
    input  logic             Branch_taken_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IF_IDWrite,
    output logic             pipeline_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic use_rs1;
    logic use_rs2;
    logic lu;
    logic at_limit;
    logic frz;

    assign use_rs1 = !((OPCODE_ID == OP_LUI) || (OPCODE_ID == OP_AUIPC) ||
                       (OPCODE_ID == OP_JAL));
    assign use_rs2 = (OPCODE_ID == OP_RTYPE) || (OPCODE_ID == OP_STORE) ||
                     (OPCODE_ID == OP_BRANCH);

    assign lu = MemRead_EX && (RD_EX != 5'd0) &&
                ((use_rs1 && (RD_EX == RS1_ID)) || (use_rs2 && (RD_EX == RS2_ID)));

    // wait_q holds the frozen MEM_WAIT cycles still allowed. Together with the
    // RUN detection cycle this bounds a freeze to MEM_TIMEOUT+1 cycles; when it
    // reaches zero the freeze is released even though memory is not ready.
    assign at_limit = (state_q == MEM_WAIT) && (wait_q == '0);
    assign frz      = mem_req_MEM && !mem_ready && !at_limit;

    always_comb begin
        PCWrite        = 1'b1;
        IF_IDWrite     = 1'b1;
        pipeline_stall = 1'b0;
        IF_ID_flush    = 1'b0;
        ID_EX_flush    = 1'b0;
        pipe_freeze    = 1'b0;
        if (reset) begin
            PCWrite    = 1'b1;
            IF_IDWrite = 1'b1;
        end else if (frz) begin
            // Every stage holds, so no bubble; branch and load-use wait for
            // the first unfrozen cycle, where EX contents are unchanged.
            pipe_freeze = 1'b1;
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
        end else if (Branch_taken_EX) begin
            // ID holds a wrong-path instruction, so its hazard is irrelevant.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (lu) begin
            PCWrite        = 1'b0;
            IF_IDWrite     = 1'b0;
            pipeline_stall = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        stall_d   = stall_q;

        if ((pipe_freeze || pipeline_stall) && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end

        case (state_q)
            RUN: begin
                if (frz) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(MEM_TIMEOUT);
                end
            end
            MEM_WAIT: begin
                if (!mem_req_MEM || mem_ready) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == '0) begin
                    state_d   = RUN;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;

endmodule
